serial_rx: RTL
==============

Name: serial_rx

Overview:
- Serial-in, parallel-out receiver for an asynchronous, UART-style frame: start bit 0, DATA_BITS data bits LSB first, optional parity bit, stop bit 1.
- Pairs with the team's serial stimulus and transmit logic, which drive a single-bit line like the flip-flop D input.
- Samples the line at mid-bit and presents each received word with a one-cycle valid strobe.
- Sits between an external serial pin and downstream word-level logic.

Parameters:
DATA_BITS, 8, data bits per frame (1..16)
CLKS_PER_BIT, 4, clock cycles per serial bit; must be even and >= 4

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
rx  input  1  serial line; idle high; asynchronous to clock
data_out  output  DATA_BITS  last correctly framed word; holds until the next good frame
data_valid  output  1  one-cycle pulse when data_out updates
frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0
parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 without PARITY_EN
busy  output  1  high in every state except IDLE

Behaviour:
- Interface is fixed: one clock, `clock`; `reset` is asynchronous and active-high.
- Reset values: data_out=0, data_valid=0, frame_err=0, parity_err=0, busy=0, state=IDLE, counters=0, both synchronizer flops=1.
- rx passes through a 2-flop synchronizer. rx_s is the second stage. All decisions use rx_s.
- Definitions: H = CLKS_PER_BIT/2, B = CLKS_PER_BIT. cnt counts clock cycles. idx counts data bits.
- IDLE: if rx_s==0, go to START with cnt=0.
- START: cnt increments each cycle. At cnt==H-1, sample rx_s:
  - 0: go to DATA with cnt=0, idx=0.
  - 1: glitch; go to IDLE with no outputs.
- DATA: at cnt==B-1, shift rx_s into the shift register MSB end (LSB first on the line), set cnt=0, idx++. After DATA_BITS samples, go to STOP (or PARITY when enabled).
- STOP: at cnt==B-1, sample rx_s:
  - 1: data_out <= shift register; data_valid=1 for the next cycle; go to IDLE.
  - 0: frame_err=1 for the next cycle; data_out unchanged; go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. A held-low line (break) yields exactly one frame_err.
- Latency: if rx is first sampled low at edge k, the stop sample occurs at edge k+2+H+(DATA_BITS+1)*B (k+40 for the defaults). data_valid is high in the cycle after that edge.
- Back-to-back frames: the receiver returns to IDLE at mid-stop-bit, so a start bit immediately after the stop bit is caught with no lost frame.
- data_valid and frame_err are never high in the same cycle.
- Reset mid-frame aborts immediately. Outputs return to reset values. The partial word is discarded. The receiver resumes in IDLE; if the line is still low it treats the line as a new start bit, which is then validated by the START check.

Optional Feature:
Macro: SERIAL_RX_PARITY_EN

With the macro defined:
- A PARITY state follows DATA and lasts B cycles, sampling at cnt==B-1.
- Even parity is checked: the XOR of the data bits and the parity bit must be 0.
- On mismatch, parity_err pulses for one cycle, coinciding with the cycle where data_valid would assert.
- The word is still loaded and data_valid still pulses, provided the stop bit is good.
- Frame latency grows by B.

Without the macro:
- There is no PARITY state.
- parity_err is tied to 0.

Test Plan:
- Defaults; reset 10 ns, then send 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) -> data_out=0xA5; data_valid high for exactly one cycle, at k+40; frame_err=0; busy high from k+2 until data_valid.
- rx low for 1 clock cycle, then high -> START rejects the glitch; busy returns to 0 after H cycles; no data_valid or frame_err; data_out unchanged.
- Send 0x3C, then a frame with stop bit 0, then line high -> frame_err one pulse; data_out stays 0x3C; no data_valid; a following good 0x81 frame gives data_out=0x81.
- Back-to-back 0x00 then 0xFF with no idle gap -> two data_valid pulses 10*B=40 cycles apart; values 0x00 then 0xFF.
- Assert reset for 1 cycle mid-way through the data bits of 0x5A, then send 0x77 -> all outputs 0 after reset; no valid for 0x5A; data_out=0x77 with one data_valid.
- With SERIAL_RX_PARITY_EN, send 0x0F with parity 0, then 0x0F with parity 1 -> first: data_valid only; second: data_valid plus parity_err pulse in the same cycle; data_out=0x0F both times.

Source files
------------

// File: rtl/serial_rx.sv
// UART-style serial receiver: start 0, DATA_BITS data bits LSB first, stop 1, mid-bit sampling.
// Define SERIAL_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
`timescale 1ns/1ps

module serial_rx #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t               state, state_n;
    logic                 rx_meta, rx_s;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n, shift_in;
    logic [DATA_BITS-1:0] data_out_n;
    logic                 data_valid_n, frame_err_n;
`ifdef SERIAL_RX_PARITY_EN
    logic                 par_bad, par_bad_n, parity_err_n;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shreg      <= shreg_n;
            data_out   <= data_out_n;
            data_valid <= data_valid_n;
            frame_err  <= frame_err_n;
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bad    <= par_bad_n;
            parity_err <= parity_err_n;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        idx_n        = idx;
        shreg_n      = shreg;
        data_out_n   = data_out;
        data_valid_n = 1'b0;
        frame_err_n  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_bad_n    = par_bad;
        parity_err_n = 1'b0;
`endif
        // LSB arrives first, so each new bit enters at the MSB end
        shift_in                = shreg >> 1;
        shift_in[DATA_BITS-1]   = rx_s;

        case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = shift_in;
                    idx_n   = idx + IDX_W'(1);
                    if (idx == IDX_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_n     = '0;
                    par_bad_n = (^shreg) ^ rx_s;
                    state_n   = STOP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                // Leaving at mid-stop-bit lets a start bit right after the stop bit be caught
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
`ifdef SERIAL_RX_PARITY_EN
                    parity_err_n = par_bad;
`endif
                    if (rx_s) begin
                        data_out_n   = shreg;
                        data_valid_n = 1'b1;
                        state_n      = IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
